control_unit_seq: RTL and testbench

CONTROL_UNIT_SEQ -- requirements
Module: control_unit_seq

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/prio_enc.sv | 18 +
 rtl/control_unit_seq.sv | 183 ++++++++++++++++++
 tb/tb_control_unit_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM state type and the ID/EX control bundle.
package cpu_pkg;

  // Instruction class codes, taken from instr[27:25]
  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BLOCK  = 3'b100;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  // ALU opcodes used for address and target generation
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  typedef enum logic {ST_IDLE = 1'b0, ST_BLOCK = 1'b1} cu_state_e;

  // Width-independent part of the control bundle
  typedef struct packed {
    logic       ctrl_valid;
    logic       shift_imm;
    logic [3:0] alu_op;
    logic       s_bit;
    logic       rf_enable;
    logic       mem_enable;
    logic       mem_rw;
    logic [1:0] mem_size;
    logic       load_inst;
    logic       b_instr;
    logic       b_l;
    logic       undef;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  // Bundle for one LDM/STM word beat; up selects add/sub, ld selects load
  function automatic ctrl_bundle_t beat_bundle(input logic up, input logic ld);
    ctrl_bundle_t b;
    b            = CTRL_NOP;
    b.ctrl_valid = 1'b1;
    b.mem_enable = 1'b1;
    b.alu_op     = up ? ALU_ADD : ALU_SUB;
    b.load_inst  = ld;
    b.rf_enable  = ld;
    b.mem_rw     = ~ld;
    return b;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit encoder; returns 0 when no bit is set.
module prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] in_bits,
  output logic [W-1:0] idx
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_bits[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/control_unit_seq.sv
// ID-stage decoder with registered ID/EX control bundle and an LDM/STM beat sequencer.
module control_unit_seq
  import cpu_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int RIDX_W   = $clog2(NREG),
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                flush,
  output logic                ctrl_valid,
  output logic                shift_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                s_bit,
  output logic                rf_enable,
  output logic                mem_enable,
  output logic                mem_rw,
  output logic [1:0]          mem_size,
  output logic                load_inst,
  output logic                b_instr,
  output logic                b_l,
  output logic [RIDX_W-1:0]   bt_reg,
  output logic [RIDX_W+1:0]   bt_offset,
  output logic                busy,
  output logic                undef
);

  cu_state_e          state_q, state_d;
  ctrl_bundle_t       ctrl_q, ctrl_d;
  logic [RIDX_W-1:0]  bt_reg_q, bt_reg_d;
  logic [RIDX_W+1:0]  bt_off_q, bt_off_d;
  logic               busy_q, busy_d;
  logic [NREG-1:0]    mask_q, mask_d;   // register-list bits still to issue
  logic [RIDX_W-1:0]  cnt_q, cnt_d;     // beat number of the next beat
  logic               up_q, up_d;       // latched U bit for the sequence
  logic               ld_q, ld_d;       // latched L bit for the sequence

  logic [2:0]         cls;
  logic [NREG-1:0]    lst, pe_in, rest;
  logic [RIDX_W-1:0]  pe_idx;

  assign cls   = instr[27:25];
  assign lst   = instr[NREG-1:0];
  // In IDLE the encoder looks at the fresh list, in BLOCK at what is left
  assign pe_in = (state_q == ST_BLOCK) ? mask_q : lst;
  // Clearing the lowest set bit tells us whether more beats follow
  assign rest  = pe_in & (pe_in - NREG'(1));

  prio_enc #(.N(NREG), .W(RIDX_W)) u_prio_enc (
    .in_bits (pe_in),
    .idx     (pe_idx)
  );

  // Next-state decode: flush beats stall, stall freezes everything
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    bt_reg_d = bt_reg_q;
    bt_off_d = bt_off_q;
    busy_d   = busy_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    ld_d     = ld_q;
    if (flush) begin
      state_d  = ST_IDLE;
      ctrl_d   = CTRL_NOP;
      bt_reg_d = '0;
      bt_off_d = '0;
      busy_d   = 1'b0;
      mask_d   = '0;
      cnt_d    = '0;
    end else if (!stall) begin
      if (state_q == ST_IDLE) begin
        ctrl_d   = CTRL_NOP;
        bt_reg_d = '0;
        bt_off_d = '0;
        busy_d   = 1'b0;
        mask_d   = '0;
        cnt_d    = '0;
        if (instr_valid && instr != 32'd0) begin
          case (cls)
            CLS_DP_REG, CLS_DP_IMM: begin
              ctrl_d.ctrl_valid = 1'b1;
              ctrl_d.alu_op     = instr[24:21];
              ctrl_d.s_bit      = instr[20];
              ctrl_d.rf_enable  = 1'b1;
              ctrl_d.shift_imm  = (cls == CLS_DP_REG);
            end
            CLS_LS_IMM, CLS_LS_REG: begin
              ctrl_d.ctrl_valid = 1'b1;
              ctrl_d.alu_op     = instr[23] ? ALU_ADD : ALU_SUB;
              ctrl_d.mem_enable = 1'b1;
              ctrl_d.mem_size   = instr[22:21];
              ctrl_d.load_inst  = instr[20];
              ctrl_d.rf_enable  = instr[20];
              ctrl_d.mem_rw     = ~instr[20];
            end
            CLS_BRANCH: begin
              ctrl_d.ctrl_valid = 1'b1;
              ctrl_d.b_instr    = 1'b1;
              ctrl_d.b_l        = instr[24];
              ctrl_d.alu_op     = instr[24] ? ALU_ADD : ALU_SUB;
            end
            CLS_BLOCK: begin
              // Empty list stays a plain NOP; otherwise beat 0 issues now
              if (lst != '0) begin
                ctrl_d   = beat_bundle(instr[23], instr[20]);
                bt_reg_d = pe_idx;
                busy_d   = (rest != '0);
                if (rest != '0) begin
                  state_d = ST_BLOCK;
                  mask_d  = rest;
                  cnt_d   = RIDX_W'(1);
                  up_d    = instr[23];
                  ld_d    = instr[20];
                end
              end
            end
            default: ctrl_d.undef = 1'b1;
          endcase
        end
      end else begin
        ctrl_d   = beat_bundle(up_q, ld_q);
        bt_reg_d = pe_idx;
        bt_off_d = {cnt_q, 2'b00};
        busy_d   = (rest != '0);
        mask_d   = rest;
        cnt_d    = cnt_q + RIDX_W'(1);
        if (rest == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  // ID/EX control register and sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= CTRL_NOP;
      bt_reg_q <= '0;
      bt_off_q <= '0;
      busy_q   <= 1'b0;
      mask_q   <= '0;
      cnt_q    <= '0;
      up_q     <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      bt_reg_q <= bt_reg_d;
      bt_off_q <= bt_off_d;
      busy_q   <= busy_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      ld_q     <= ld_d;
    end
  end

  assign ctrl_valid = ctrl_q.ctrl_valid;
  assign shift_imm  = ctrl_q.shift_imm;
  assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);
  assign s_bit      = ctrl_q.s_bit;
  assign rf_enable  = ctrl_q.rf_enable;
  assign mem_enable = ctrl_q.mem_enable;
  assign mem_rw     = ctrl_q.mem_rw;
  assign mem_size   = ctrl_q.mem_size;
  assign load_inst  = ctrl_q.load_inst;
  assign b_instr    = ctrl_q.b_instr;
  assign b_l        = ctrl_q.b_l;
  assign undef      = ctrl_q.undef;
  assign bt_reg     = bt_reg_q;
  assign bt_offset  = bt_off_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed-vector bench for control_unit_seq with hand-computed bundles.
module tb_control_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        ctrl_valid, shift_imm, s_bit, rf_enable, mem_enable, mem_rw;
  logic        load_inst, b_instr, b_l, busy, undef;
  logic [3:0]  alu_op, bt_reg;
  logic [1:0]  mem_size;
  logic [5:0]  bt_offset;

  int vecs = 0;
  int fails = 0;
  logic [26:0] exp;

  control_unit_seq dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .ctrl_valid(ctrl_valid), .shift_imm(shift_imm),
    .alu_op(alu_op), .s_bit(s_bit), .rf_enable(rf_enable), .mem_enable(mem_enable),
    .mem_rw(mem_rw), .mem_size(mem_size), .load_inst(load_inst), .b_instr(b_instr),
    .b_l(b_l), .bt_reg(bt_reg), .bt_offset(bt_offset), .busy(busy), .undef(undef)
  );

  always #5 clk = ~clk;

  wire [26:0] obs = {ctrl_valid, shift_imm, alu_op, s_bit, rf_enable, mem_enable, mem_rw,
                     mem_size, load_inst, b_instr, b_l, bt_reg, bt_offset, busy, undef};

  // Packs an expected bundle in the same field order as obs
  function automatic logic [26:0] mk(input logic cv, input logic si, input logic [3:0] alu,
      input logic s, input logic rf, input logic me, input logic rw, input logic [1:0] sz,
      input logic ld, input logic b, input logic bl, input logic [3:0] r,
      input logic [5:0] off, input logic bz, input logic ud);
    return {cv, si, alu, s, rf, me, rw, sz, ld, b, bl, r, off, bz, ud};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    instr = 32'hE0912003; instr_valid = 1'b1;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL reset_state: got %h want %h", obs, 27'd0); end
    rst_n = 1'b1;
  endtask

  task automatic test_dp;
    // first edge after reset release decodes the ADDS already on instr
    tick;
    exp = mk(1,1,4'h4,1,1,0,0,2'd0,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL dp_adds: got %h want %h", obs, exp); end
    instr = 32'hE2812001;
    tick;
    exp = mk(1,0,4'h4,0,1,0,0,2'd0,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL dp_imm: got %h want %h", obs, exp); end
  endtask

  task automatic test_ldst;
    instr = 32'hE5912004;
    tick;
    exp = mk(1,0,4'h4,0,1,1,0,2'd0,1,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL ldr: got %h want %h", obs, exp); end
    instr = 32'hE5C12004;
    tick;
    exp = mk(1,0,4'h4,0,0,1,1,2'd2,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL strb_size: got %h want %h", obs, exp); end
    instr = 32'hE7112004;
    tick;
    exp = mk(1,0,4'h2,0,1,1,0,2'd0,1,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL ldr_down: got %h want %h", obs, exp); end
  endtask

  task automatic test_branch;
    instr = 32'hEB000010;
    tick;
    exp = mk(1,0,4'h4,0,0,0,0,2'd0,0,1,1,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL bl: got %h want %h", obs, exp); end
    instr = 32'hEA000010;
    tick;
    exp = mk(1,0,4'h2,0,0,0,0,2'd0,0,1,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL b: got %h want %h", obs, exp); end
  endtask

  task automatic test_nop_undef;
    instr = 32'hE0912003; instr_valid = 1'b0;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL bubble: got %h want %h", obs, 27'd0); end
    instr = 32'd0; instr_valid = 1'b1;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL zero_instr: got %h want %h", obs, 27'd0); end
    instr = 32'hEE000000;
    tick;
    exp = mk(0,0,4'h0,0,0,0,0,2'd0,0,0,0,4'd0,6'd0,0,1);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL undef_111: got %h want %h", obs, exp); end
    instr = 32'hEC000000;
    tick;
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL undef_110: got %h want %h", obs, exp); end
    instr = 32'hE8900000;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL empty_list: got %h want %h", obs, 27'd0); end
  endtask

  task automatic test_single_bit;
    instr = 32'hE8900020;
    tick;
    exp = mk(1,0,4'h4,0,1,1,0,2'd0,1,0,0,4'd5,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL ldm_single: got %h want %h", obs, exp); end
    instr = 32'd0;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL ldm_single_done: got %h want %h", obs, 27'd0); end
  endtask

  task automatic test_stm;
    logic [3:0] r [3];
    logic [5:0] o [3];
    logic       b [3];
    r = '{4'd0, 4'd2, 4'd4}; o = '{6'd0, 6'd4, 6'd8}; b = '{1'b1, 1'b1, 1'b0};
    instr = 32'hE8800015;
    for (int i = 0; i < 3; i++) begin
      tick;
      exp = mk(1,0,4'h4,0,0,1,1,2'd0,0,0,0,r[i],o[i],b[i],0);
      vecs++;
      if (obs !== exp) begin fails++; $display("FAIL stm_beat%0d: got %h want %h", i, obs, exp); end
    end
    instr = 32'd0;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL stm_done: got %h want %h", obs, 27'd0); end
  endtask

  task automatic test_stall;
    logic       st [6];
    logic [3:0] r  [6];
    logic [5:0] o  [6];
    logic       b  [6];
    // stall in IDLE keeps the previous decode
    instr = 32'hE0912003;
    tick;
    stall = 1'b1; instr = 32'hE5912004;
    tick;
    exp = mk(1,1,4'h4,1,1,0,0,2'd0,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL stall_idle: got %h want %h", obs, exp); end
    stall = 1'b0;
    st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    r  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
    o  = '{6'd0, 6'd4, 6'd4, 6'd4, 6'd8, 6'd12};
    b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    instr = 32'hE810000F;
    for (int i = 0; i < 6; i++) begin
      stall = st[i];
      tick;
      exp = mk(1,0,4'h2,0,1,1,0,2'd0,1,0,0,r[i],o[i],b[i],0);
      vecs++;
      if (obs !== exp) begin fails++; $display("FAIL stall_clk%0d: got %h want %h", i, obs, exp); end
    end
    stall = 1'b0; instr = 32'd0;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL stall_done: got %h want %h", obs, 27'd0); end
  endtask

  task automatic test_flush;
    instr = 32'hE89FFFFF;
    tick;
    exp = mk(1,0,4'h4,0,1,1,0,2'd0,1,0,0,4'd0,6'd0,1,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL flush_beat0: got %h want %h", obs, exp); end
    flush = 1'b1;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL flush_nop: got %h want %h", obs, 27'd0); end
    flush = 1'b0; instr = 32'hE0912003;
    tick;
    exp = mk(1,1,4'h4,1,1,0,0,2'd0,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL flush_idle: got %h want %h", obs, exp); end
  endtask

  task automatic test_flush_stall;
    instr = 32'hE89FFFFF;
    tick;
    tick;
    exp = mk(1,0,4'h4,0,1,1,0,2'd0,1,0,0,4'd1,6'd4,1,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL fs_beat1: got %h want %h", obs, exp); end
    flush = 1'b1; stall = 1'b1;
    tick;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL fs_nop: got %h want %h", obs, 27'd0); end
    flush = 1'b0; stall = 1'b0; instr = 32'hE5912004;
    tick;
    exp = mk(1,0,4'h4,0,1,1,0,2'd0,1,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL fs_idle: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid;
    instr = 32'hE89FFFFF;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs !== 27'd0) begin fails++; $display("FAIL reset_async: got %h want %h", obs, 27'd0); end
    instr = 32'hE2812001;
    #1 rst_n = 1'b1;
    tick;
    exp = mk(1,0,4'h4,0,1,0,0,2'd0,0,0,0,4'd0,6'd0,0,0);
    vecs++;
    if (obs !== exp) begin fails++; $display("FAIL reset_first_decode: got %h want %h", obs, exp); end
  endtask

  initial begin
    test_reset;
    test_dp;
    test_ldst;
    test_branch;
    test_nop_undef;
    test_single_bit;
    test_stm;
    test_stall;
    test_flush;
    test_flush_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
